// File: rtl/register_storage_pkg.sv
// Shared definitions for the register-storage serializer/deserializer pair.
// Both directions use the same two-state IDLE/SHIFT encoding.
package register_storage_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_e;

endpackage

// File: rtl/register_storage_piso_4_bit_counter.sv
// Bit position counter for a WIDTH-bit word; saturates at WIDTH-1 and
// flags the final position with a registered at_last.
module bit_index_counter #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       inc,
    output logic [$clog2(WIDTH)-1:0]   index,
    output logic                       at_last
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    logic [IW-1:0] index_q, index_d;
    logic          at_last_q, at_last_d;

    always_comb begin
        index_d   = index_q;
        at_last_d = at_last_q;
        if (inc && !at_last_q) begin
            index_d   = index_q + 1'b1;
            at_last_d = (index_d == LAST_IDX);
        end
    end

    // WIDTH >= 2, so index 0 is never the last position.
    always_ff @(posedge clk) begin
        if (clear) begin
            index_q   <= '0;
            at_last_q <= 1'b0;
        end else begin
            index_q   <= index_d;
            at_last_q <= at_last_d;
        end
    end

    assign index   = index_q;
    assign at_last = at_last_q;

endmodule

// File: rtl/register_storage_piso_4_bit.sv
// Parallel-in serial-out register with valid/ready handshakes on both sides.
// A new word may load on the edge that consumes the last bit, giving gapless streams.
module register_storage_piso_4_bit #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             last_bit
);

    import register_storage_pkg::*;

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    shift_state_e     state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, shreg_shifted;
    logic [IW-1:0]    index;
    logic             at_last;
    logic             accept, consume, word_done;
    logic             cnt_clear;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
            assign serial_out    = shreg_q[WIDTH-1];
        end else begin : g_lsb_first
            assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
            assign serial_out    = shreg_q[0];
        end
    endgenerate

    assign serial_valid = (state_q == ST_SHIFT);
    assign last_bit     = at_last;
    assign consume      = serial_valid && serial_ready;
    assign word_done    = consume && (index == LAST_IDX);
    // A word can only enter when the slot is empty or is being vacated this edge.
    assign in_ready     = !clear && ((state_q == ST_IDLE) || (at_last && serial_ready));
    assign accept       = in_valid && in_ready;
    assign cnt_clear    = clear || accept || word_done;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        if (accept) begin
            state_d = ST_SHIFT;
            shreg_d = parallel_in;
        end else if (word_done) begin
            state_d = ST_IDLE;
            shreg_d = '0;
        end else if (consume) begin
            shreg_d = shreg_shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    bit_index_counter #(
        .WIDTH (WIDTH)
    ) u_bit_index_counter (
        .clk     (clk),
        .clear   (cnt_clear),
        .inc     (consume),
        .index   (index),
        .at_last (at_last)
    );

endmodule
